// File: rtl/avl_arb_pkg.sv
// Shared types for the Avalon port arbiter: FSM state encoding, requester IDs
// and the timeout-counter width helper.
package avl_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // Width of a counter that must reach timeout_cyc; at least one bit so a
    // disabled timeout (0) still yields a legal vector.
    function automatic int unsigned cnt_width(input int unsigned timeout_cyc);
        return (timeout_cyc == 0) ? 1 : $clog2(timeout_cyc + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker.
//   iCLK, iRST_n  : clock, async active-low reset
//   req[1:0]      : request vector indexed by port_e (bit0 = IF, bit1 = D)
//   update        : commit the current pick as the new last grant
//   gnt_valid_c   : combinational, some request is present
//   gnt_port_c    : combinational, port picked this cycle
module rr_arbiter2
    import avl_arb_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRST_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic       gnt_valid_c,
    output port_e      gnt_port_c
);

    port_e last_grant;

    // On a tie, favour the port that was not served last.
    always_comb begin
        gnt_valid_c = |req;
        gnt_port_c  = PORT_IF;
        if (req == 2'b11) begin
            gnt_port_c = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (req[1]) begin
            gnt_port_c = PORT_D;
        end
    end

    // Reset to D so the first tie goes to IF.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            last_grant <= PORT_D;
        end else if (update && gnt_valid_c) begin
            last_grant <= gnt_port_c;
        end
    end

endmodule

// File: rtl/avl_port_arbiter.sv
// Shares one Avalon-MM master between the CPU instruction-fetch port (IF,
// read-only) and data port (D, read/write). One non-pipelined transaction at
// a time: command held through waitrequest, then readdatavalid wait with an
// optional timeout. Completion is a one-cycle ack with rdata/err to the
// granted port.
//   iCLK, iRST_n                       : clock, async active-low reset
//   if_req/if_addr -> if_ack/if_rdata/if_err
//   d_req/d_we/d_addr/d_wdata/d_be -> d_ack/d_rdata/d_err
//   avl_wait/avl_rData_valid/avl_rData : Avalon slave responses
//   avl_addr/avl_wData/avl_byteenable/avl_read/avl_write/avl_size : master
module avl_port_arbiter
    import avl_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 28,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,

    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic                  if_ack,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_err,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,

    input  logic                  avl_wait,
    input  logic                  avl_rData_valid,
    input  logic [DATA_W-1:0]     avl_rData,
    output logic [ADDR_W-1:0]     avl_addr,
    output logic [DATA_W-1:0]     avl_wData,
    output logic [DATA_W/8-1:0]   avl_byteenable,
    output logic                  avl_read,
    output logic                  avl_write,
    output logic                  avl_size
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);

    arb_state_e          state, state_nxt;
    port_e               grant_port, grant_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;

    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;
    logic [BE_W-1:0]     be_nxt;
    logic                read_nxt, write_nxt;
    logic                if_ack_nxt, d_ack_nxt;
    logic                if_err_nxt, d_err_nxt;
    logic [DATA_W-1:0]   if_rdata_nxt, d_rdata_nxt;

    logic                gnt_valid_c;
    port_e               gnt_port_c;
    logic                arb_update_c;
    logic                finish_c, fin_err_c, capture_c;

    // Single-beat transfers only.
    assign avl_size = 1'b1;

    rr_arbiter2 u_rr (
        .iCLK        (iCLK),
        .iRST_n      (iRST_n),
        .req         ({d_req, if_req}),
        .update      (arb_update_c),
        .gnt_valid_c (gnt_valid_c),
        .gnt_port_c  (gnt_port_c)
    );

    // State and all registered outputs.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state          <= IDLE;
            grant_port     <= PORT_IF;
            cnt            <= '0;
            avl_addr       <= '0;
            avl_wData      <= '0;
            avl_byteenable <= '0;
            avl_read       <= 1'b0;
            avl_write      <= 1'b0;
            if_ack         <= 1'b0;
            if_err         <= 1'b0;
            if_rdata       <= '0;
            d_ack          <= 1'b0;
            d_err          <= 1'b0;
            d_rdata        <= '0;
        end else begin
            state          <= state_nxt;
            grant_port     <= grant_nxt;
            cnt            <= cnt_nxt;
            avl_addr       <= addr_nxt;
            avl_wData      <= wdata_nxt;
            avl_byteenable <= be_nxt;
            avl_read       <= read_nxt;
            avl_write      <= write_nxt;
            if_ack         <= if_ack_nxt;
            if_err         <= if_err_nxt;
            if_rdata       <= if_rdata_nxt;
            d_ack          <= d_ack_nxt;
            d_err          <= d_err_nxt;
            d_rdata        <= d_rdata_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_port;
        cnt_nxt      = cnt;
        addr_nxt     = avl_addr;
        wdata_nxt    = avl_wData;
        be_nxt       = avl_byteenable;
        read_nxt     = avl_read;
        write_nxt    = avl_write;
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;
        if_err_nxt   = if_err;
        d_err_nxt    = d_err;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        arb_update_c = 1'b0;
        finish_c     = 1'b0;
        fin_err_c    = 1'b0;
        capture_c    = 1'b0;

        case (state)
            IDLE: begin
                if (gnt_valid_c) begin
                    arb_update_c = 1'b1;
                    grant_nxt    = gnt_port_c;
                    state_nxt    = CMD;
                    if (gnt_port_c == PORT_IF) begin
                        addr_nxt  = if_addr;
                        wdata_nxt = '0;
                        be_nxt    = '1;
                        read_nxt  = 1'b1;
                        write_nxt = 1'b0;
                    end else begin
                        addr_nxt  = d_addr;
                        wdata_nxt = d_wdata;
                        be_nxt    = d_be;
                        read_nxt  = !d_we;
                        write_nxt = d_we;
                    end
                end
            end

            CMD: begin
                if (!avl_wait) begin
                    if (avl_write) begin
                        write_nxt = 1'b0;
                        finish_c  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        read_nxt  = 1'b0;
                        cnt_nxt   = '0;
                        state_nxt = RESP;
                    end
                end
            end

            RESP: begin
                // Data arriving on the last allowed cycle still wins over timeout.
                if (avl_rData_valid) begin
                    finish_c  = 1'b1;
                    capture_c = 1'b1;
                    state_nxt = DONE;
                end else if ((TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC))) begin
                    finish_c  = 1'b1;
                    fin_err_c = 1'b1;
                    state_nxt = DONE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Ack is loaded on entry to DONE so it is high exactly while in DONE.
        if (finish_c) begin
            if (grant_port == PORT_IF) begin
                if_ack_nxt = 1'b1;
                if_err_nxt = fin_err_c;
                if (capture_c) begin
                    if_rdata_nxt = avl_rData;
                end
            end else begin
                d_ack_nxt = 1'b1;
                d_err_nxt = fin_err_c;
                if (capture_c) begin
                    d_rdata_nxt = avl_rData;
                end
            end
        end
    end

endmodule

// File: tb/tb_avl_port_arbiter.sv
// Scoreboard bench for avl_port_arbiter: stimulus pushes expected Avalon
// commands and port completions; negedge monitors pop and compare.
module tb_avl_port_arbiter;
    import avl_arb_pkg::*;

    localparam int unsigned ADDR_W  = 28;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned TB_TMO  = 4;

    logic                iCLK;
    logic                iRST_n;
    logic                if_req;
    logic [ADDR_W-1:0]   if_addr;
    logic                if_ack;
    logic [DATA_W-1:0]   if_rdata;
    logic                if_err;
    logic                d_req;
    logic                d_we;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [3:0]          d_be;
    logic                d_ack;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_err;
    logic                avl_wait;
    logic                avl_rData_valid;
    logic [DATA_W-1:0]   avl_rData;
    logic [ADDR_W-1:0]   avl_addr;
    logic [DATA_W-1:0]   avl_wData;
    logic [3:0]          avl_byteenable;
    logic                avl_read;
    logic                avl_write;
    logic                avl_size;

    avl_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (TB_TMO)
    ) dut (
        .iCLK            (iCLK),
        .iRST_n          (iRST_n),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_ack          (if_ack),
        .if_rdata        (if_rdata),
        .if_err          (if_err),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_be            (d_be),
        .d_ack           (d_ack),
        .d_rdata         (d_rdata),
        .d_err           (d_err),
        .avl_wait        (avl_wait),
        .avl_rData_valid (avl_rData_valid),
        .avl_rData       (avl_rData),
        .avl_addr        (avl_addr),
        .avl_wData       (avl_wData),
        .avl_byteenable  (avl_byteenable),
        .avl_read        (avl_read),
        .avl_write       (avl_write),
        .avl_size        (avl_size)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        be;
        int                len;
    } cmd_t;

    typedef struct {
        port_e             port;
        logic              err;
        logic [DATA_W-1:0] if_rd;
        logic [DATA_W-1:0] d_rd;
    } ack_t;

    cmd_t cmd_q[$];
    ack_t ack_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] m_if_rdata = '0;
    logic [DATA_W-1:0] m_d_rdata  = '0;

    // Avalon slave model controls
    int                slv_wait_left = 0;
    int                slv_vdelay    = 0;
    logic [DATA_W-1:0] slv_rdata     = '0;
    logic              stray         = 1'b0;
    logic [DATA_W-1:0] stray_data    = '0;
    logic              rd_pend       = 1'b0;
    int                resp_cnt      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_cmd(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input logic [3:0] be, input int len);
        cmd_t c;
        c.we = we; c.addr = addr; c.wdata = wdata; c.be = be; c.len = len;
        cmd_q.push_back(c);
    endtask

    task automatic push_ack(input port_e p, input logic err, input logic upd,
                            input logic [DATA_W-1:0] rdata);
        ack_t a;
        if (upd) begin
            if (p == PORT_IF) m_if_rdata = rdata;
            else              m_d_rdata  = rdata;
        end
        a.port = p; a.err = err; a.if_rd = m_if_rdata; a.d_rd = m_d_rdata;
        ack_q.push_back(a);
    endtask

    // Avalon slave: waitrequest for slv_wait_left command cycles, then
    // readdatavalid after slv_vdelay RESP cycles (negative = never).
    always @(negedge iCLK) begin
        if (!iRST_n) begin
            avl_wait        = 1'b0;
            avl_rData_valid = 1'b0;
            rd_pend         = 1'b0;
        end else begin
            avl_rData_valid = 1'b0;
            if (avl_read || avl_write) begin
                if (slv_wait_left > 0) begin
                    avl_wait = 1'b1;
                    slv_wait_left--;
                end else begin
                    avl_wait = 1'b0;
                end
                rd_pend  = avl_read;
                resp_cnt = 0;
            end else begin
                avl_wait = 1'b0;
                if (if_ack || d_ack) rd_pend = 1'b0;
                if (rd_pend) begin
                    if (slv_vdelay >= 0 && resp_cnt == slv_vdelay) begin
                        avl_rData_valid = 1'b1;
                        avl_rData       = slv_rdata;
                        rd_pend         = 1'b0;
                    end else begin
                        resp_cnt++;
                    end
                end else if (stray) begin
                    avl_rData_valid = 1'b1;
                    avl_rData       = stray_data;
                end
            end
        end
    end

    // Command monitor
    cmd_t cur_cmd;
    logic prev_cmd = 1'b0;
    int   run_len  = 0;
    always @(negedge iCLK) begin
        if (!iRST_n) begin
            prev_cmd = 1'b0;
            run_len  = 0;
        end else begin
            if ((avl_read || avl_write) && !prev_cmd) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd_start", 64'(avl_addr), 64'hFFFF_FFFF);
                end else begin
                    cur_cmd = cmd_q.pop_front();
                    check("cmd_we",   64'(avl_write), 64'(cur_cmd.we));
                    check("cmd_read", 64'(avl_read),  64'(!cur_cmd.we));
                    check("cmd_be",   64'(avl_byteenable), 64'(cur_cmd.be));
                    if (cur_cmd.we) check("cmd_wdata", 64'(avl_wData), 64'(cur_cmd.wdata));
                end
                run_len = 0;
            end
            if (avl_read || avl_write) begin
                run_len++;
                check("cmd_addr_stable", 64'(avl_addr), 64'(cur_cmd.addr));
                check("cmd_rw_exclusive", 64'(avl_read & avl_write), 64'd0);
            end
            if (!(avl_read || avl_write) && prev_cmd) begin
                check("cmd_len", 64'(run_len), 64'(cur_cmd.len));
            end
            prev_cmd = avl_read || avl_write;
        end
    end

    // Completion monitor
    ack_t cur_ack;
    always @(negedge iCLK) begin
        if (iRST_n && (if_ack || d_ack)) begin
            check("ack_onehot", 64'(if_ack & d_ack), 64'd0);
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 64'({if_ack, d_ack}), 64'd0);
            end else begin
                cur_ack = ack_q.pop_front();
                check("ack_port", 64'(d_ack), 64'(cur_ack.port == PORT_D));
                check("ack_err", (cur_ack.port == PORT_D) ? 64'(d_err) : 64'(if_err), 64'(cur_ack.err));
                check("if_rdata", 64'(if_rdata), 64'(cur_ack.if_rd));
                check("d_rdata",  64'(d_rdata),  64'(cur_ack.d_rd));
                check("avl_size", 64'(avl_size), 64'd1);
            end
        end
    end

    // Single request; latency counted in posedges from driving req to ack.
    task automatic run_txn(input port_e p, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input logic [3:0] be,
                           input int wait_c, input int vdelay, input logic [DATA_W-1:0] rdata,
                           input int exp_lat, input string name);
        int   lat;
        logic got;
        logic rd;
        logic tmo;
        lat = 0;
        got = 1'b0;
        rd  = (p == PORT_IF) || !we;
        tmo = rd && (vdelay < 0);
        if (p == PORT_IF) push_cmd(1'b0, addr, '0, 4'hF, wait_c + 1);
        else              push_cmd(we, addr, wdata, be, wait_c + 1);
        push_ack(p, tmo, rd && !tmo, rdata);
        slv_wait_left = wait_c;
        slv_vdelay    = vdelay;
        slv_rdata     = rdata;
        if (p == PORT_IF) begin
            if_addr = addr;
            if_req  = 1'b1;
        end else begin
            d_we    = we;
            d_addr  = addr;
            d_wdata = wdata;
            d_be    = be;
            d_req   = 1'b1;
        end
        while (!got && lat < 64) begin
            @(posedge iCLK); #1;
            lat++;
            got = (p == PORT_IF) ? if_ack : d_ack;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        if_req = 1'b0;
        d_req  = 1'b0;
        @(posedge iCLK); #1;
    endtask

    // Requester that drops req in DONE and re-raises in the following IDLE.
    task automatic requester(input port_e p, input int n, input logic [ADDR_W-1:0] base);
        for (int k = 0; k < n; k++) begin
            int   cyc;
            logic got;
            cyc = 0;
            got = 1'b0;
            if (p == PORT_IF) begin
                if_addr = base + ADDR_W'(4 * k);
                if_req  = 1'b1;
            end else begin
                d_we    = 1'b1;
                d_addr  = base + ADDR_W'(4 * k);
                d_wdata = 32'hD000_0000 + DATA_W'(k);
                d_be    = 4'h3;
                d_req   = 1'b1;
            end
            while (!got && cyc < 64) begin
                @(posedge iCLK); #1;
                cyc++;
                got = (p == PORT_IF) ? if_ack : d_ack;
            end
            check("requester_ack_seen", 64'(got), 64'd1);
            if (p == PORT_IF) if_req = 1'b0;
            else              d_req  = 1'b0;
            @(posedge iCLK); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST_n = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        avl_rData = '0;
        repeat (3) @(posedge iCLK);
        #1;
        check("rst_avl_read",  64'(avl_read),  64'd0);
        check("rst_avl_write", 64'(avl_write), 64'd0);
        check("rst_avl_addr",  64'(avl_addr),  64'd0);
        check("rst_avl_size",  64'(avl_size),  64'd1);
        check("rst_if_ack",    64'(if_ack),    64'd0);
        check("rst_d_ack",     64'(d_ack),     64'd0);
        check("rst_if_rdata",  64'(if_rdata),  64'd0);
        check("rst_d_rdata",   64'(d_rdata),   64'd0);
        iRST_n = 1'b1;
        @(posedge iCLK); #1;

        // Plain D write, no waitrequest
        run_txn(PORT_D, 1'b1, 28'h000_0010, 32'hA5A5_A5A5, 4'hF, 0, 0, '0, 2, "t1_d_write");

        // Contention: IF reads vs D writes, both held and re-requested
        slv_wait_left = 0;
        slv_vdelay    = 0;
        slv_rdata     = 32'h0BAD_0001;
        push_cmd(1'b0, 28'h100, '0, 4'hF, 1);             push_ack(PORT_IF, 1'b0, 1'b1, 32'h0BAD_0001);
        push_cmd(1'b1, 28'h200, 32'hD000_0000, 4'h3, 1);  push_ack(PORT_D,  1'b0, 1'b0, '0);
        push_cmd(1'b0, 28'h104, '0, 4'hF, 1);             push_ack(PORT_IF, 1'b0, 1'b1, 32'h0BAD_0001);
        push_cmd(1'b1, 28'h204, 32'hD000_0001, 4'h3, 1);  push_ack(PORT_D,  1'b0, 1'b0, '0);
        fork
            requester(PORT_IF, 2, 28'h100);
            requester(PORT_D,  2, 28'h200);
        join

        // IF read with 3 waitrequest cycles and data on the second RESP cycle
        run_txn(PORT_IF, 1'b0, 28'h000_0020, '0, 4'hF, 3, 1, 32'h1234_5678, 7, "t2_if_read");

        // D reads: immediate data, data on the last allowed cycle, then timeout
        run_txn(PORT_D, 1'b0, 28'h300, '0, 4'hF, 0, 0,  32'hCAFE_F00D, 3, "t4_d_read");
        run_txn(PORT_D, 1'b0, 28'h304, '0, 4'hF, 0, 4,  32'h0F0F_0F0F, 7, "t4_d_read_last");
        run_txn(PORT_D, 1'b0, 28'h308, '0, 4'hF, 1, -1, 32'h7777_7777, 8, "t4_d_timeout");

        // Late data while idle must be ignored
        stray_data = 32'hDEAD_BEEF;
        stray      = 1'b1;
        repeat (3) @(posedge iCLK);
        #1;
        stray = 1'b0;
        check("stray_d_rdata",  64'(d_rdata),  64'(m_d_rdata));
        check("stray_if_rdata", 64'(if_rdata), 64'(m_if_rdata));
        check("stray_avl_read", 64'(avl_read), 64'd0);

        // Reset during CMD of a stalled write
        slv_wait_left = 1000;
        push_cmd(1'b1, 28'h040, 32'h55AA_55AA, 4'hC, 0);
        d_we = 1'b1; d_addr = 28'h040; d_wdata = 32'h55AA_55AA; d_be = 4'hC; d_req = 1'b1;
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        check("t5_write_in_cmd", 64'(avl_write), 64'd1);
        #2;
        iRST_n = 1'b0;
        #1;
        check("t5_rst_avl_write", 64'(avl_write), 64'd0);
        check("t5_rst_avl_read",  64'(avl_read),  64'd0);
        check("t5_rst_d_ack",     64'(d_ack),     64'd0);
        check("t5_rst_if_ack",    64'(if_ack),    64'd0);
        d_req         = 1'b0;
        slv_wait_left = 0;
        m_if_rdata    = '0;
        m_d_rdata     = '0;
        @(posedge iCLK);
        #3;
        iRST_n = 1'b1;
        @(posedge iCLK); #1;
        run_txn(PORT_D, 1'b1, 28'h044, 32'h1357_9BDF, 4'h5, 0, 0, '0, 2, "t5_after_rst");

        // First tie after reset goes to IF
        slv_rdata  = 32'h0BAD_0002;
        slv_vdelay = 0;
        push_cmd(1'b0, 28'h500, '0, 4'hF, 1);            push_ack(PORT_IF, 1'b0, 1'b1, 32'h0BAD_0002);
        push_cmd(1'b1, 28'h600, 32'hD000_0000, 4'h3, 1); push_ack(PORT_D,  1'b0, 1'b0, '0);
        iRST_n = 1'b0;
        #2;
        iRST_n = 1'b1;
        @(posedge iCLK); #1;
        fork
            requester(PORT_IF, 1, 28'h500);
            requester(PORT_D,  1, 28'h600);
        join

        repeat (4) @(posedge iCLK);
        #1;
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
        check("ack_queue_drained", 64'(ack_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avl_port_arbiter.md
Name: avl_port_arbiter

Overview:
- Shares the single Avalon-MM master of the memory management path between the CPU instruction-fetch port (IF, read-only) and the CPU data port (D, read/write).
- Grants one requester at a time with two-way round-robin, then runs one non-pipelined Avalon transaction: waitrequest hold, then readdatavalid wait with timeout.
- Returns read data, a one-cycle ack and an error flag to the granted port.
- Sits between the CPU core and the SDRAM/Avalon fabric.

Parameters:
- ADDR_W, 28, Avalon and port address width.
- DATA_W, 32, data width (byteenable width is DATA_W/8).
- TIMEOUT_CYC, 255, maximum cycles in RESP waiting for readdatavalid; 0 disables the timeout.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRST_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request, level, held until if_ack.
- if_addr  in  ADDR_W  IF address, stable while if_req.
- if_ack  out  1  one-cycle completion pulse.
- if_rdata  out  DATA_W  IF read data, valid with if_ack, held until the next IF completion.
- if_err  out  1  timeout error, valid with if_ack.
- d_req  in  1  D request, level, held until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  D address.
- d_wdata  in  DATA_W  D write data.
- d_be  in  DATA_W/8  D byte enables.
- d_ack  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_W  D read data, valid with d_ack, held until the next D read completion.
- d_err  out  1  timeout error, valid with d_ack.
- avl_wait  in  1  Avalon waitrequest.
- avl_rData_valid  in  1  Avalon readdatavalid.
- avl_rData  in  DATA_W  Avalon readdata.
- avl_addr  out  ADDR_W  Avalon address (registered).
- avl_wData  out  DATA_W  Avalon writedata (registered).
- avl_byteenable  out  DATA_W/8  Avalon byteenable (registered).
- avl_read  out  1  Avalon read (registered).
- avl_write  out  1  Avalon write (registered).
- avl_size  out  1  burst count, constant 1.

Behaviour:
- Reset (asynchronous, iRST_n=0): state=IDLE; last_grant=D; all outputs 0 except avl_size=1; timeout counter=0. Reset mid-transaction abandons it; no ack is issued.
- States: IDLE, CMD, RESP, DONE. All outputs are registered.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requesting: grant the port that is not last_grant, so the first tie after reset goes to IF.
- On grant: latch addr, wdata, be and we into the avl_* registers. IF forces be=all ones and we=0. Set avl_write=we and avl_read=!we, update last_grant, go to CMD.
- CMD: hold all avl_* outputs while avl_wait=1.
  - avl_wait=0, write: clear avl_write, go to DONE.
  - avl_wait=0, read: clear avl_read, clear the counter, go to RESP.
- RESP, avl_rData_valid=1: capture avl_rData into the granted port's rdata, err=0, go to DONE.
- RESP, TIMEOUT_CYC≠0 and counter==TIMEOUT_CYC with no valid: err=1, rdata unchanged, go to DONE. Otherwise increment the counter.
- DONE: the granted port's ack=1 for exactly this cycle, then go to IDLE. The requester drops req on the next edge.
- Minimum latency, write: IDLE(sample) → CMD → DONE(ack) = ack 2 cycles after req is sampled.
- Minimum latency, read with valid on the first RESP cycle: ack 3 cycles after req is sampled.
- avl_rData_valid outside RESP (e.g. late data after a timeout) is ignored.
- Requests arriving while not in IDLE wait; IF/D signals are sampled only in IDLE.
- Counter width is $clog2(TIMEOUT_CYC+1); it saturates and never wraps.

Decomposition:
- Package avl_arb_pkg: state encoding (IDLE=2'd0, CMD=2'd1, RESP=2'd2, DONE=2'd3) and port IDs (PORT_IF=1'b0, PORT_D=1'b1).
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req[1:0] and last_grant, with a registered last_grant update on an enable.

Test Plan:
- Reset release, then d_req write, addr=0x0000010, wdata=0xA5A5A5A5, be=4'hF, avl_wait=0 → avl_write high for 1 cycle with those values; d_ack 2 cycles after sampling; d_err=0.
- IF read addr=0x0000020; avl_wait held high 3 cycles; avl_rData_valid with 0x12345678 two cycles after acceptance → avl_read held 4 cycles with stable addr; if_ack with if_rdata=0x12345678.
- if_req and d_req asserted in the same cycle, both held and re-requested → grant order IF, D, IF, D; no port is granted twice in a row while the other is waiting.
- D read, TIMEOUT_CYC=4, readdatavalid never asserted → d_ack with d_err=1 after 5 RESP cycles, d_rdata unchanged; a later stray avl_rData_valid is ignored.
- iRST_n pulsed low during CMD of a write with avl_wait=1 → avl_write, avl_read and acks drop to 0 immediately; state returns to IDLE; the next request completes normally.
